data_mem_responder: RTL
=======================

# data_mem_responder

Memory-side responder for the CPU's data-memory port. It accepts one load/store request at a time over a valid/ready request channel and returns a completion over a valid/ready response channel. Each request has a programmable number of wait states. The block owns a 512-byte little-endian byte array and supports byte or 16-bit word access. It replaces the CPU's direct enable-strobed memory access with a handshaked responder that tolerates wait states and back-pressure.

## Interface
- ADDR_LIMIT, 512: number of bytes implemented; valid byte addresses are 0..ADDR_LIMIT-1.
- WAIT_CYCLES, 1: wait states inserted between request acceptance and memory commit (0..15).

- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = 16-bit word access.
- req_signed  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  16  byte address.
- req_wdata  in  16  store data; byte stores use [7:0].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  16  load data; 0 for stores and errors.
- rsp_err  out  1  request rejected (address out of range).

## Operation
- Only one request may be outstanding. All request fields are captured on acceptance, when req_valid && req_ready. After acceptance the input fields may change freely.
- State machine:
  - IDLE: req_ready=1. On acceptance, load the wait counter with WAIT_CYCLES and go to WAIT, or go directly to COMMIT if WAIT_CYCLES=0.
  - WAIT: decrement the counter each cycle. Go to COMMIT in the cycle the counter reaches 1.
  - COMMIT: one cycle.
    - Perform the write, or latch the read data into rsp_rdata.
    - Set rsp_err and go to RESP.
  - RESP: rsp_valid=1. Hold rsp_rdata and rsp_err stable until rsp_ready=1, then go to IDLE.
- Address check:
  - Byte access is an error if addr >= ADDR_LIMIT.
  - Word access is an error if addr+1 >= ADDR_LIMIT. Compute this in 17 bits so 16'hFFFF does not wrap.
  - On error: memory is unchanged, rsp_rdata=0, rsp_err=1.
- Word layout is little-endian: mem[a] holds bits [7:0] and mem[a+1] holds bits [15:8]. Odd word addresses are legal.
- Byte load: rsp_rdata = {8{sign}}, mem[a]}, where sign = req_signed & mem[a][7].
- Byte store writes mem[a] only. Word store writes both bytes in the same COMMIT cycle.
- Store response: rsp_valid with rsp_rdata=0 and rsp_err=0.
- Memory contents are zero at time 0 and are not affected by rst.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. All outputs are registered.
- Latency: if a request is accepted at edge N, rsp_valid rises after edge N+WAIT_CYCLES+1. Example: WAIT_CYCLES=1 gives rsp_valid high 2 cycles after acceptance.
- req_ready falls in the cycle after acceptance. It stays low through WAIT, COMMIT and RESP. It rises in the cycle after the response handshake.
- Maximum throughput is one request per WAIT_CYCLES+3 cycles.
- Back-pressure: rsp_valid may be held indefinitely while rsp_ready=0. No other request is accepted during that time.
- A store's effect is visible to any load accepted after the store's response handshake.
- Reset mid-operation:
  - rst in IDLE or WAIT: the request is dropped and memory is unchanged.
  - rst in COMMIT: the store still commits at that edge, no response is issued, and the state returns to IDLE.
  - rst in RESP: the response is dropped and the store remains committed.
- req_valid asserted while rst=1 is ignored.

## Test plan
- Word store then load, WAIT_CYCLES=1:
  - Store addr=6, wdata=16'hA55A, then load addr=6 → rsp_rdata=16'hA55A, rsp_err=0.
  - mem[6]=8'h5A and mem[7]=8'hA5.
  - rsp_valid rises exactly 2 cycles after each acceptance.
- Byte access:
  - Store byte addr=9, wdata=16'h1280 → only mem[9]=8'h80; mem[8] and mem[10] unchanged.
  - Byte load with req_signed=1 → 16'hFF80; with req_signed=0 → 16'h0080.
- Boundary and error:
  - Word load at addr=510 → no error.
  - Word store at addr=511 → rsp_err=1 and mem[511] unchanged.
  - Byte load at addr=511 → no error.
  - Byte load at addr=16'hFFFF → rsp_err=1, rsp_rdata=0.
- Back-pressure: hold rsp_ready=0 for 5 cycles → rsp_valid stays high with stable data and req_ready stays 0. req_ready returns 1 the cycle after rsp_ready=1.
- WAIT_CYCLES=0 back-to-back: with req_valid held high and rsp_ready held high, requests are accepted every 3 cycles and each response follows 1 cycle after acceptance.
- Reset mid-request: assert rst during WAIT of a store to addr=20 → that memory location is unchanged and rsp_valid never rises. After reset, req_ready=1 and a load of addr=20 returns its prior value.

Source files
------------

// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: one outstanding load/store into a small
// little-endian byte array, with programmable wait states before commit.
`timescale 1ns/1ps
module data_mem_responder #(
  parameter int unsigned ADDR_LIMIT  = 512,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (ADDR_LIMIT > 1) ? $clog2(ADDR_LIMIT) : 1;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COMMIT,
    ST_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           req_ready_q, req_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic           rsp_err_q, rsp_err_d;

  logic           write_q, write_d;
  logic           byte_q, byte_d;
  logic           signed_q, signed_d;
  logic [DW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;

  // Storage is deliberately outside the reset domain.
  logic [7:0]     mem_q [ADDR_LIMIT];

  logic [AW-1:0]  idx_lo, idx_hi;
  logic [7:0]     rd_lo, rd_hi;
  logic [16:0]    addr_ext;
  logic           acc_err;
  logic           mem_we_lo, mem_we_hi;

  // Range check in 17 bits so a word at 16'hFFFF cannot wrap back into range.
  always_comb begin
    addr_ext = {1'b0, addr_q};
    if (byte_q) begin
      acc_err = (addr_ext >= 17'(ADDR_LIMIT));
    end else begin
      acc_err = ((addr_ext + 17'd1) >= 17'(ADDR_LIMIT));
    end
    idx_lo = addr_q[AW-1:0];
    idx_hi = AW'(addr_q + 16'd1);
    rd_lo  = mem_q[idx_lo];
    rd_hi  = mem_q[idx_hi];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    write_d     = write_q;
    byte_d      = byte_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_we_lo   = 1'b0;
    mem_we_hi   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d  = req_write;
          byte_d   = req_byte;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_COMMIT;
          end else begin
            cnt_d   = CW'(WAIT_CYCLES);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = ST_COMMIT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_COMMIT: begin
        rsp_err_d   = acc_err;
        rsp_rdata_d = '0;
        if (!acc_err) begin
          if (write_q) begin
            mem_we_lo = 1'b1;
            mem_we_hi = !byte_q;
          end else if (byte_q) begin
            rsp_rdata_d = {{8{signed_q & rd_lo[7]}}, rd_lo};
          end else begin
            rsp_rdata_d = {rd_hi, rd_lo};
          end
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs are registered copies of the next state.
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      write_q     <= 1'b0;
      byte_q      <= 1'b0;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      write_q     <= write_d;
      byte_q      <= byte_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // A store in COMMIT lands even if rst is asserted on the same edge.
  always_ff @(posedge clk) begin
    if (mem_we_lo) begin
      mem_q[idx_lo] <= wdata_q[7:0];
    end
    if (mem_we_hi) begin
      mem_q[idx_hi] <= wdata_q[15:8];
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
